// File: rtl/ds_link_traffic_bist.sv
`default_nettype none
// ============================================================================
// Module   : ds_link_traffic_bist
// Purpose  : DS-link traffic generator and checker (PRBS / incrementing /
//            NULL-lookalike) with error, timeout and overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module ds_link_traffic_bist #(
    parameter int G_DATA_WIDTH     = 8,
    parameter int G_LEN_WIDTH      = 16,
    parameter int G_ERR_WIDTH      = 16,
    parameter int G_TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [G_LEN_WIDTH-1:0]  len,
    input  logic [15:0]             seed,
    output logic [G_DATA_WIDTH-1:0] tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [G_DATA_WIDTH-1:0] rx_data,
    input  logic                    rx_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [G_ERR_WIDTH-1:0]  err_count,
    output logic [G_LEN_WIDTH-1:0]  rx_count,
    output logic                    timeout,
    output logic                    overrun
);

    localparam logic [15:0] c_lfsr_init = 16'hACE1;
    localparam int          c_to_width  = $clog2(G_TIMEOUT_CYCLES + 1);
    localparam logic [c_to_width-1:0] c_to_last = c_to_width'(G_TIMEOUT_CYCLES - 1);
    localparam logic [G_LEN_WIDTH-1:0] c_len_one = G_LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   r_gen_state;
    state_t                   r_chk_state;
    logic [1:0]               r_mode;
    logic [G_LEN_WIDTH-1:0]   r_len;
    logic [G_LEN_WIDTH-1:0]   r_gen_idx;
    logic [G_LEN_WIDTH-1:0]   r_chk_idx;
    logic [15:0]              r_gen_lfsr;
    logic [15:0]              r_chk_lfsr;
    logic [2:0]               r_gen_ph;
    logic [2:0]               r_chk_ph;
    logic [c_to_width-1:0]    r_idle_cnt;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic                     r_timeout;
    logic                     r_overrun;
    logic [G_ERR_WIDTH-1:0]   r_err_count;
    logic [G_LEN_WIDTH-1:0]   r_rx_count;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [2:0] ph_next(input logic [2:0] p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Mode 3 falls into the default branch and behaves as incrementing.
    function automatic logic [G_DATA_WIDTH-1:0] seq_word(
        input logic [1:0]             m,
        input logic [15:0]            l,
        input logic [G_LEN_WIDTH-1:0] idx,
        input logic [2:0]             p
    );
        logic [7:0] n;
        case (p)
            3'd0:        n = 8'hE6;
            3'd1, 3'd2:  n = 8'h2E;
            default:     n = 8'h3E;
        endcase
        case (m)
            2'd0:    return G_DATA_WIDTH'(l);
            2'd2:    return G_DATA_WIDTH'(n);
            default: return G_DATA_WIDTH'(idx);
        endcase
    endfunction

    logic                    w_accept;
    logic [15:0]             w_seed;
    logic [G_DATA_WIDTH-1:0] w_gen_word;
    logic [G_DATA_WIDTH-1:0] w_chk_word;
    logic                    w_tx_fire;
    logic                    w_rx_chk;
    logic                    w_ovr_now;
    logic                    w_mismatch;
    logic                    w_timeout_hit;
    logic                    w_complete;

    assign w_accept      = start && !r_busy;
    assign w_seed        = (seed == 16'd0) ? c_lfsr_init : seed;
    assign w_gen_word    = seq_word(r_mode, r_gen_lfsr, r_gen_idx, r_gen_ph);
    assign w_chk_word    = seq_word(r_mode, r_chk_lfsr, r_chk_idx, r_chk_ph);
    assign w_tx_fire     = (r_gen_state == ST_RUN) && tx_ready;
    assign w_rx_chk      = rx_valid && (r_chk_state == ST_RUN) && !w_accept;
    // Words landing after the checker has finished are overruns; IDLE never
    // follows a completed test because the FSMs park in DONE until restart.
    assign w_ovr_now     = rx_valid && (r_chk_state == ST_DONE) && !w_accept;
    assign w_mismatch    = w_rx_chk && (rx_data != w_chk_word);
    assign w_timeout_hit = (r_chk_state == ST_RUN) && !rx_valid && (r_idle_cnt == c_to_last);
    assign w_complete    = r_busy && (r_gen_state == ST_DONE) && (r_chk_state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen_state <= ST_IDLE;
            r_chk_state <= ST_IDLE;
            r_mode      <= 2'd0;
            r_len       <= '0;
            r_gen_idx   <= '0;
            r_chk_idx   <= '0;
            r_gen_lfsr  <= c_lfsr_init;
            r_chk_lfsr  <= c_lfsr_init;
            r_gen_ph    <= 3'd0;
            r_chk_ph    <= 3'd0;
            r_idle_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_err_count <= '0;
            r_rx_count  <= '0;
        end else if (w_accept) begin
            r_mode      <= mode;
            r_len       <= len;
            r_gen_idx   <= '0;
            r_chk_idx   <= '0;
            r_gen_lfsr  <= w_seed;
            r_chk_lfsr  <= w_seed;
            r_gen_ph    <= 3'd0;
            r_chk_ph    <= 3'd0;
            r_idle_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_err_count <= '0;
            r_rx_count  <= '0;
            if (len == '0) begin
                r_gen_state <= ST_DONE;
                r_chk_state <= ST_DONE;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_pass      <= 1'b1;
            end else begin
                r_gen_state <= ST_RUN;
                r_chk_state <= ST_RUN;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end
        end else begin
            if (w_tx_fire) begin
                r_gen_idx  <= r_gen_idx + c_len_one;
                r_gen_lfsr <= lfsr_next(r_gen_lfsr);
                r_gen_ph   <= ph_next(r_gen_ph);
                if (r_gen_idx == r_len - c_len_one) begin
                    r_gen_state <= ST_DONE;
                end
            end

            if (w_rx_chk) begin
                r_chk_idx  <= r_chk_idx + c_len_one;
                r_chk_lfsr <= lfsr_next(r_chk_lfsr);
                r_chk_ph   <= ph_next(r_chk_ph);
                r_idle_cnt <= '0;
                if (~&r_rx_count) begin
                    r_rx_count <= r_rx_count + c_len_one;
                end
                if (r_chk_idx == r_len - c_len_one) begin
                    r_chk_state <= ST_DONE;
                end
            end else if (r_chk_state == ST_RUN) begin
                if (w_timeout_hit) begin
                    r_timeout   <= 1'b1;
                    r_chk_state <= ST_DONE;
                    r_gen_state <= ST_DONE;
                end else begin
                    r_idle_cnt <= r_idle_cnt + c_to_width'(1);
                end
            end

            if (w_ovr_now) begin
                r_overrun <= 1'b1;
            end
            if ((w_mismatch || w_ovr_now) && ~&r_err_count) begin
                r_err_count <= r_err_count + G_ERR_WIDTH'(1);
            end

            if (w_complete) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (r_err_count == '0) && !r_timeout && !r_overrun && !w_ovr_now;
            end else if (w_ovr_now) begin
                r_pass <= 1'b0;
            end
        end
    end

    assign tx_valid  = (r_gen_state == ST_RUN);
    assign tx_data   = tx_valid ? w_gen_word : '0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign rx_count  = r_rx_count;
    assign timeout   = r_timeout;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
